quiz_round_ctrl: RTL and testbench

QUIZ_ROUND_CTRL -- requirements
Module: quiz_round_ctrl

---
 rtl/quiz_pkg.sv | 49 ++++
 rtl/quiz_round_ctrl_if.sv | 31 +++
 rtl/quiz_phase_timer.sv | 27 ++
 rtl/quiz_round_ctrl.sv | 171 +++++++++++++++++
 tb/tb_quiz_round_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/quiz_pkg.sv
// Shared types for the quiz round controller: FSM states, operator codes, display codes.
// Also holds the result and answer-judging helpers used by the controller.
package quiz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GEN    = 3'd1,
        ST_SHOW_A = 3'd2,
        ST_SHOW_B = 3'd3,
        ST_ANSWER = 3'd4,
        ST_SHOW_R = 3'd5,
        ST_OVER   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_INV = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        DISP_BLANK = 2'd0,
        DISP_A     = 2'd1,
        DISP_B     = 2'd2,
        DISP_RES   = 2'd3
    } disp_t;

    localparam logic [3:0] POINT_MAX = 4'd9;

    // Operands are stored as a >= b, so subtraction never wraps.
    function automatic logic [7:0] calc_result(input logic [3:0] a, input logic [3:0] b,
                                               input op_t op);
        logic [7:0] res;
        case (op)
            OP_ADD:  res = {4'd0, a} + {4'd0, b};
            OP_SUB:  res = {4'd0, a} - {4'd0, b};
            OP_MUL:  res = {4'd0, a} * {4'd0, b};
            default: res = 8'd0;
        endcase
        return res;
    endfunction

    // Right answer: exactly one rising button, and it matches a valid operator.
    function automatic logic is_right(input logic [3:0] rise, input op_t op);
        return (op != OP_INV) && (rise == (4'd1 << op));
    endfunction

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// Bundle of start, operand-generator handshake, answer buttons and display/score outputs.
// master = round controller, slave = environment (generator, buttons, display).
interface quiz_round_ctrl_if;
    import quiz_pkg::*;

    logic       start;
    logic       gen_req;
    logic       gen_ack;
    logic [3:0] gen_a;
    logic [3:0] gen_b;
    logic [1:0] gen_op;
    logic [3:0] switch;
    disp_t      disp_sel;
    logic [7:0] disp_val;
    op_t        operator;
    logic [3:0] point;
    logic       correct;
    logic       round_done;
    logic       game_over;

    modport master (
        input  start, gen_ack, gen_a, gen_b, gen_op, switch,
        output gen_req, disp_sel, disp_val, operator, point, correct, round_done, game_over
    );

    modport slave (
        output start, gen_ack, gen_a, gen_b, gen_op, switch,
        input  gen_req, disp_sel, disp_val, operator, point, correct, round_done, game_over
    );

endinterface

// File: rtl/quiz_phase_timer.sv
// Loadable down-counter; done is high while the count is zero. Load takes effect next cycle.
// No backpressure: counts down every cycle and holds at zero.
module quiz_phase_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/quiz_round_ctrl.sv
// Arithmetic quiz round sequencer: fetch operands, show A/B, collect answer, show result, score.
// Outputs registered (one cycle after the deciding edge); generator stalls GEN via gen_ack.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int unsigned PHASE_TICKS  = 8,
    parameter int unsigned ANSWER_TICKS = 64,
    parameter int unsigned ROUNDS       = 9
) (
    input  logic               clk,
    input  logic               reset,
    quiz_round_ctrl_if.master  bus
);

    localparam int unsigned MAX_TICKS = (PHASE_TICKS > ANSWER_TICKS) ? PHASE_TICKS : ANSWER_TICKS;
    localparam int unsigned TW        = $clog2(MAX_TICKS + 1);
    localparam logic [TW-1:0] PHASE_LOAD  = TW'(PHASE_TICKS - 1);
    localparam logic [TW-1:0] ANSWER_LOAD = TW'(ANSWER_TICKS - 1);
    localparam logic [3:0]    LAST_ROUND  = 4'(ROUNDS - 1);

    state_t     state;
    logic [3:0] a_q;
    logic [3:0] b_q;
    op_t        op_q;
    logic [3:0] switch_prev;
    logic [3:0] round_cnt;
    logic [3:0] point_q;
    logic       gen_req_q;
    disp_t      disp_sel_q;
    logic [7:0] disp_val_q;
    logic       correct_q;
    logic       round_done_q;
    logic       game_over_q;

    logic [3:0]    rise;
    logic [3:0]    hi;
    logic [3:0]    lo;
    logic          gen_take;
    logic          answer_end;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    // switch_prev tracks the buttons continuously, so a button already held on ANSWER entry shows no rise.
    assign rise       = bus.switch & ~switch_prev;
    assign hi         = (bus.gen_a >= bus.gen_b) ? bus.gen_a : bus.gen_b;
    assign lo         = (bus.gen_a >= bus.gen_b) ? bus.gen_b : bus.gen_a;
    assign gen_take   = (state == ST_GEN) && gen_req_q && bus.gen_ack;
    assign answer_end = (state == ST_ANSWER) && ((rise != 4'd0) || tmr_done);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = PHASE_LOAD;
        case (state)
            ST_GEN:    tmr_load = gen_take;
            ST_SHOW_A: tmr_load = tmr_done;
            ST_SHOW_B: begin
                tmr_load = tmr_done;
                tmr_val  = ANSWER_LOAD;
            end
            ST_ANSWER: tmr_load = answer_end;
            default:   tmr_load = 1'b0;
        endcase
    end

    quiz_phase_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            op_q         <= OP_ADD;
            switch_prev  <= 4'd0;
            round_cnt    <= 4'd0;
            point_q      <= 4'd0;
            gen_req_q    <= 1'b0;
            disp_sel_q   <= DISP_BLANK;
            disp_val_q   <= 8'd0;
            correct_q    <= 1'b0;
            round_done_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            switch_prev  <= bus.switch;
            correct_q    <= 1'b0;
            round_done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        state       <= ST_GEN;
                        gen_req_q   <= 1'b1;
                        point_q     <= 4'd0;
                        round_cnt   <= 4'd0;
                        game_over_q <= 1'b0;
                    end
                end
                ST_GEN: begin
                    if (gen_take) begin
                        state      <= ST_SHOW_A;
                        gen_req_q  <= 1'b0;
                        a_q        <= hi;
                        b_q        <= lo;
                        op_q       <= op_t'(bus.gen_op);
                        disp_sel_q <= DISP_A;
                        disp_val_q <= {4'd0, hi};
                    end
                end
                ST_SHOW_A: begin
                    if (tmr_done) begin
                        state      <= ST_SHOW_B;
                        disp_sel_q <= DISP_B;
                        disp_val_q <= {4'd0, b_q};
                    end
                end
                ST_SHOW_B: begin
                    if (tmr_done) begin
                        state      <= ST_ANSWER;
                        disp_sel_q <= DISP_BLANK;
                        disp_val_q <= 8'd0;
                    end
                end
                ST_ANSWER: begin
                    // A rise in the final answer cycle is judged like any other; timeout only covers "no rise".
                    if (answer_end) begin
                        state      <= ST_SHOW_R;
                        disp_sel_q <= DISP_RES;
                        disp_val_q <= calc_result(a_q, b_q, op_q);
                        if (is_right(rise, op_q)) begin
                            correct_q <= 1'b1;
                            if (point_q != POINT_MAX) begin
                                point_q <= point_q + 4'd1;
                            end
                        end
                    end
                end
                ST_SHOW_R: begin
                    if (tmr_done) begin
                        round_done_q <= 1'b1;
                        round_cnt    <= round_cnt + 4'd1;
                        disp_sel_q   <= DISP_BLANK;
                        disp_val_q   <= 8'd0;
                        if (round_cnt == LAST_ROUND) begin
                            state       <= ST_OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            state     <= ST_GEN;
                            gen_req_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gen_req    = gen_req_q;
    assign bus.disp_sel   = disp_sel_q;
    assign bus.disp_val   = disp_val_q;
    assign bus.operator   = op_q;
    assign bus.point      = point_q;
    assign bus.correct    = correct_q;
    assign bus.round_done = round_done_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: table of directed rounds plus random rounds against a round-level model.
// A second 3-round instance shares the stimulus to observe an early game over.
module tb_quiz_round_ctrl;
    import quiz_pkg::*;

    localparam int P = 2;
    localparam int A = 5;
    localparam int R = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    quiz_round_ctrl_if bus();
    quiz_round_ctrl_if bus3();

    quiz_round_ctrl #(.PHASE_TICKS(P), .ANSWER_TICKS(A), .ROUNDS(R)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
    quiz_round_ctrl #(.PHASE_TICKS(P), .ANSWER_TICKS(A), .ROUNDS(3)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3));

    assign bus3.start   = bus.start;
    assign bus3.gen_ack = bus.gen_ack;
    assign bus3.gen_a   = bus.gen_a;
    assign bus3.gen_b   = bus.gen_b;
    assign bus3.gen_op  = bus.gen_op;
    assign bus3.switch  = bus.switch;

    typedef struct {
        logic [3:0] ga;
        logic [3:0] gb;
        logic [1:0] op;
        logic [3:0] press;
        int         delay;
        bit         hold;
        logic [7:0] exp_res;
        bit         exp_ok;
    } vec_t;

    vec_t vecs[17];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_point = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input int ga, input int gb, input int op, input int press,
                                input int delay, input int hold, input int res, input int ok);
        vec_t v;
        v.ga = 4'(ga); v.gb = 4'(gb); v.op = 2'(op); v.press = 4'(press);
        v.delay = delay; v.hold = (hold != 0); v.exp_res = 8'(res); v.exp_ok = (ok != 0);
        return v;
    endfunction

    function automatic logic [7:0] model_result(input int a, input int b, input int op);
        int h, l;
        h = (a > b) ? a : b;
        l = (a > b) ? b : a;
        case (op)
            0:       return 8'(h + l);
            1:       return 8'(h - l);
            2:       return 8'(h * l);
            default: return 8'd0;
        endcase
    endfunction

    function automatic bit model_ok(input logic [3:0] press, input int op);
        if ($countones(press) != 1) return 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (press[n] && n == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.ga = 4'($urandom_range(0, 9));
        v.gb = 4'($urandom_range(0, 9));
        v.op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0:       v.press = 4'd0;
            1:       v.press = 4'd1 << v.op;
            2:       v.press = 4'd1 << $urandom_range(0, 3);
            default: v.press = 4'($urandom_range(1, 15));
        endcase
        v.delay   = $urandom_range(0, A - 1);
        v.hold    = 1'b0;
        v.exp_res = model_result(v.ga, v.gb, v.op);
        v.exp_ok  = model_ok(v.press, v.op);
        return v;
    endfunction

    task automatic play_round(input vec_t v, input string tag);
        int hi, lo, alen;
        bit got;
        hi = (v.ga > v.gb) ? v.ga : v.gb;
        lo = (v.ga > v.gb) ? v.gb : v.ga;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (bus.gen_req === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, " gen_req_seen"}, 32'(got), 1);
        if (!got) return;
        check({tag, " blank_in_gen"}, bus.disp_sel, 0);
        bus.gen_ack = 1'b1; bus.gen_a = v.ga; bus.gen_b = v.gb; bus.gen_op = v.op;
        @(negedge clk);
        bus.gen_ack = 1'b0; bus.gen_a = 4'd0; bus.gen_b = 4'd0; bus.gen_op = 2'd0;
        check({tag, " gen_req_drop"}, bus.gen_req, 0);
        check({tag, " operator"}, bus.operator, v.op);
        for (int i = 0; i < P; i++) begin
            check({tag, " show_a_sel"}, bus.disp_sel, 1);
            check({tag, " show_a_val"}, bus.disp_val, hi);
            @(negedge clk);
        end
        for (int i = 0; i < P; i++) begin
            if (v.hold && i == 0) bus.switch = v.press;
            check({tag, " show_b_sel"}, bus.disp_sel, 2);
            check({tag, " show_b_val"}, bus.disp_val, lo);
            @(negedge clk);
        end
        alen = (v.hold || v.press == 4'd0) ? A : v.delay + 1;
        for (int k = 0; k < alen; k++) begin
            check({tag, " answer_sel"}, bus.disp_sel, 0);
            check({tag, " answer_val"}, bus.disp_val, 0);
            if (!v.hold && v.press != 4'd0 && k == v.delay) bus.switch = v.press;
            @(negedge clk);
        end
        if (v.exp_ok && model_point < 9) model_point++;
        check({tag, " answer_len"}, bus.disp_sel, 3);
        check({tag, " correct"}, bus.correct, 32'(v.exp_ok));
        check({tag, " point"}, bus.point, model_point);
        bus.switch = 4'd0;
        for (int i = 0; i < P; i++) begin
            check({tag, " show_r_sel"}, bus.disp_sel, 3);
            check({tag, " show_r_val"}, bus.disp_val, v.exp_res);
            if (i > 0) check({tag, " correct_pulse"}, bus.correct, 0);
            check({tag, " no_early_done"}, bus.round_done, 0);
            @(negedge clk);
        end
        check({tag, " round_done"}, bus.round_done, 1);
        check({tag, " sel_after"}, bus.disp_sel, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " gen_req"}, bus.gen_req, 0);
        check({tag, " disp_sel"}, bus.disp_sel, 0);
        check({tag, " disp_val"}, bus.disp_val, 0);
        check({tag, " operator"}, bus.operator, 0);
        check({tag, " point"}, bus.point, 0);
        check({tag, " correct"}, bus.correct, 0);
        check({tag, " round_done"}, bus.round_done, 0);
        check({tag, " game_over"}, bus.game_over, 0);
        check({tag, " gen_req3"}, bus3.gen_req, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.gen_ack = 1'b0; bus.gen_a = 4'd0; bus.gen_b = 4'd0;
        bus.gen_op = 2'd0; bus.switch = 4'd0;

        vecs[0]  = mk(3, 7, 0, 4'b0001, 1, 0, 10, 1);
        vecs[1]  = mk(2, 5, 1, 4'b0010, 0, 0, 3, 1);
        vecs[2]  = mk(4, 6, 2, 4'b0100, 4, 0, 24, 1);
        vecs[3]  = mk(9, 0, 0, 4'b0001, 2, 0, 9, 1);
        vecs[4]  = mk(0, 8, 1, 4'b0010, 3, 0, 8, 1);
        vecs[5]  = mk(7, 7, 1, 4'b0010, 1, 0, 0, 1);
        vecs[6]  = mk(5, 9, 2, 4'b0100, 0, 0, 45, 1);
        vecs[7]  = mk(1, 1, 0, 4'b0001, 2, 0, 2, 1);
        vecs[8]  = mk(6, 3, 0, 4'b0001, 1, 0, 9, 1);
        vecs[9]  = mk(8, 2, 2, 4'b0100, 0, 0, 16, 1);
        vecs[10] = mk(9, 9, 2, 4'b0010, 1, 0, 81, 0);
        vecs[11] = mk(4, 2, 0, 4'b0011, 1, 0, 6, 0);
        vecs[12] = mk(6, 1, 0, 4'b0000, 0, 0, 7, 0);
        vecs[13] = mk(2, 3, 1, 4'b0010, 0, 1, 1, 0);
        vecs[14] = mk(9, 4, 3, 4'b0001, 0, 0, 0, 0);
        vecs[15] = mk(5, 5, 3, 4'b1000, 2, 0, 0, 0);
        vecs[16] = mk(3, 3, 2, 4'b1000, 3, 0, 9, 0);

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_req", bus.gen_req, 0);

        // Game 1: nine correct, one saturating, two wrong.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        model_point = 0;
        for (int r = 0; r < 12; r++) begin
            play_round(vecs[r], $sformatf("g1r%0d", r));
            if (r == 2) begin
                check("dut3 game_over", bus3.game_over, 1);
                check("dut3 point", bus3.point, 3);
                check("dut3 round_done", bus3.round_done, 1);
                check("dut3 no_req", bus3.gen_req, 0);
            end
        end
        check("g1 game_over", bus.game_over, 1);
        check("g1 point_sat", bus.point, 9);
        repeat (3) @(negedge clk);
        check("g1 over_holds", bus.game_over, 1);
        check("g1 over_no_req", bus.gen_req, 0);

        // Game 2: start held through the first round must be ignored outside IDLE/OVER.
        bus.start = 1'b1;
        @(negedge clk);
        model_point = 0;
        check("g2 point_clear", bus.point, 0);
        check("g2 game_over_clear", bus.game_over, 0);
        check("g2 dut3 point_clear", bus3.point, 0);
        check("g2 dut3 game_over_clear", bus3.game_over, 0);
        check("g2 gen_req", bus.gen_req, 1);
        for (int r = 12; r < 17; r++) begin
            play_round(vecs[r], $sformatf("g2r%0d", r));
            bus.start = 1'b0;
        end
        for (int r = 0; r < 7; r++) play_round(rand_vec(), $sformatf("g2rand%0d", r));
        check("g2 game_over", bus.game_over, 1);

        // Game 3: fully random.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        model_point = 0;
        for (int r = 0; r < 12; r++) play_round(rand_vec(), $sformatf("g3rand%0d", r));
        check("g3 game_over", bus.game_over, 1);

        // Reset in the middle of a pending generator request.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("mid_gen gen_req", bus.gen_req, 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_gen_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset idle", bus.gen_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
